// File: rtl/result_reader_pkg.sv
// Shared types, segment constants and hex decode for result_byte_reader.
// Active-low 7-seg, bit order {g,f,e,d,c,b,a}.
package result_reader_pkg;

  typedef enum logic {IDLE, SHOW} state_t;

  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_R     = 7'h2F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    s = SEG_BLANK;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/result_byte_reader_hex7seg.sv
// hex7seg: 4-bit nibble to active-low 7-segment pattern.
// Pure combinational wrapper around the package decode.
module hex7seg
  import result_reader_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex_to_seg(hex_i);

endmodule

// File: rtl/result_byte_reader.sv
// Captures a 32-bit result and steps through it byte-wise on 4 displays.
// Optional auto-scroll advance: define RESULT_AUTOSCROLL_EN.
module result_byte_reader
  import result_reader_pkg::*;
#(
  parameter int unsigned SCROLL_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enter,
  input  logic [31:0] result,
  input  logic        result_valid,
  output logic        busy,
  output logic [1:0]  byte_idx,
  output logic [7:0]  byte_out,
  output logic        done,
  output logic [6:0]  disp3,
  output logic [6:0]  disp2,
  output logic [6:0]  disp1,
  output logic [6:0]  disp0
);

  state_t      state_q;
  logic [1:0]  idx_q;
  logic [31:0] result_q;
  logic        enter_q;
  logic        done_q;
  logic        rise_d;
  logic        adv_d;

  assign rise_d = enter & ~enter_q;

`ifdef RESULT_AUTOSCROLL_EN
  localparam int unsigned CW =
    (SCROLL_CYCLES > 1) ? $clog2(SCROLL_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCROLL_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic          tick_d;

  assign tick_d = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_q != SHOW || rise_d || tick_d) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign adv_d = rise_d | tick_d;
`else
  logic unused_scroll;
  assign unused_scroll = (SCROLL_CYCLES == 0);
  assign adv_d = rise_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= 2'd3;
      result_q <= '0;
      enter_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      enter_q <= enter;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // enter is ignored here, even on the load cycle
          if (result_valid) begin
            result_q <= result;
            idx_q    <= 2'd3;
            state_q  <= SHOW;
          end
        end
        SHOW: begin
          if (adv_d) begin
            if (idx_q != 2'd0) begin
              idx_q <= idx_q - 2'd1;
            end else begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = (state_q == SHOW);
  assign byte_idx = idx_q;
  assign byte_out = result_q[{idx_q, 3'b000} +: 8];
  assign done     = done_q;

  logic [6:0] seg_idx;
  logic [6:0] seg_hi;
  logic [6:0] seg_lo;

  hex7seg u_idx (
    .hex_i ({2'b00, idx_q}),
    .seg_o (seg_idx)
  );

  hex7seg u_hi (
    .hex_i (byte_out[7:4]),
    .seg_o (seg_hi)
  );

  hex7seg u_lo (
    .hex_i (byte_out[3:0]),
    .seg_o (seg_lo)
  );

  assign disp3 = busy ? SEG_R   : SEG_DASH;
  assign disp2 = busy ? seg_idx : SEG_DASH;
  assign disp1 = busy ? seg_hi  : SEG_DASH;
  assign disp0 = busy ? seg_lo  : SEG_DASH;

endmodule

// File: tb/tb_result_byte_reader.sv
// Self-checking bench for result_byte_reader: directed steps plus
// random traffic compared against a byte-stepping reference model.
module tb_result_byte_reader;

  localparam int unsigned SC = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        enter;
  logic [31:0] result;
  logic        result_valid;
  logic        busy;
  logic [1:0]  byte_idx;
  logic [7:0]  byte_out;
  logic        done;
  logic [6:0]  disp3, disp2, disp1, disp0;

  always #5 clk = ~clk;

  result_byte_reader #(.SCROLL_CYCLES(SC)) dut (
    .clk          (clk),
    .reset        (reset),
    .enter        (enter),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .byte_idx     (byte_idx),
    .byte_out     (byte_out),
    .done         (done),
    .disp3        (disp3),
    .disp2        (disp2),
    .disp1        (disp1),
    .disp0        (disp0)
  );

  localparam logic [6:0] HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  // reference model
  bit          m_show;
  bit          m_known;
  int          m_idx;
  logic [31:0] m_word;
  bit          m_prev;
  bit          m_done;
  int          m_cnt;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    bit rise, adv;
    if (reset) begin
      m_show = 0; m_known = 1; m_idx = 3; m_word = 0;
      m_prev = 0; m_done = 0; m_cnt = 0;
    end else begin
      rise = enter && !m_prev;
      adv = rise;
      m_done = 0;
`ifdef RESULT_AUTOSCROLL_EN
      if (m_show) begin
        adv = rise || (m_cnt == int'(SC) - 1);
        m_cnt = adv ? 0 : m_cnt + 1;
      end else begin
        m_cnt = 0;
      end
`endif
      if (!m_show) begin
        if (result_valid) begin
          m_word = result; m_idx = 3; m_show = 1; m_known = 1;
        end
      end else if (adv) begin
        if (m_idx > 0) m_idx--;
        else begin
          m_show = 0; m_done = 1; m_known = 0;
        end
      end
      m_prev = enter;
    end
  endtask

  task automatic check_all();
    logic [7:0] b;
    b = 8'((m_word >> (8 * m_idx)) & 32'hFF);
    chk("busy", busy, m_show);
    chk("done", done, m_done);
    if (m_show || m_known) begin
      chk("byte_idx", byte_idx, m_idx);
      chk("byte_out", byte_out, b);
    end
    chk("disp3", disp3, m_show ? 7'h2F : 7'h3F);
    chk("disp2", disp2, m_show ? HEX[m_idx] : 7'h3F);
    chk("disp1", disp1, m_show ? HEX[b[7:4]] : 7'h3F);
    chk("disp0", disp0, m_show ? HEX[b[3:0]] : 7'h3F);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (done === 1'b1) done_seen++;
    check_all();
  endtask

  task automatic press();
    enter = 1'b1;
    repeat (2) cyc();
    enter = 1'b0;
    repeat (2) cyc();
  endtask

  task automatic load(input logic [31:0] r);
    result = r;
    result_valid = 1'b1;
    cyc();
    result_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enter = 1'b0; result = '0; result_valid = 1'b0;
    m_show = 0; m_known = 1; m_idx = 3; m_word = 0;
    m_prev = 0; m_done = 0; m_cnt = 0;
    repeat (2) cyc();
    reset = 1'b0;
    cyc();
    chk("rst_disp3", disp3, 7'h3F);
    chk("rst_disp0", disp0, 7'h3F);
    chk("rst_busy", busy, 1'b0);
    chk("rst_idx", byte_idx, 2'd3);
    chk("rst_done", done, 1'b0);

    // four presses walk 0x40000000 down to byte 0 and finish
    load(32'h4000_0000);
    chk("ld_byte", byte_out, 8'h40);
    chk("ld_disp2", disp2, 7'h30);
    chk("ld_disp1", disp1, 7'h19);
    chk("ld_disp0", disp0, 7'h40);
    done_seen = 0;
    repeat (4) press();
`ifndef RESULT_AUTOSCROLL_EN
    chk("fin_done_cnt", done_seen, 1);
    chk("fin_busy", busy, 1'b0);
    chk("fin_disp1", disp1, 7'h3F);
`endif

    // held enter advances once
    load(32'h4000_0000);
    enter = 1'b1;
    repeat (10) cyc();
    enter = 1'b0;
    cyc();
`ifndef RESULT_AUTOSCROLL_EN
    chk("hold_idx", byte_idx, 2'd2);
`endif

    // new result while showing is ignored
    press();
    load(32'h3F80_0000);
    cyc();
`ifndef RESULT_AUTOSCROLL_EN
    chk("ign_idx", byte_idx, 2'd1);
    chk("ign_byte", byte_out, 8'h00);
`endif

    // reset mid-show, then a fresh load
    press();
    press();
    load(32'h0000_00AA);
    press();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("mid_busy", busy, 1'b0);
    chk("mid_disp2", disp2, 7'h3F);
    load(32'h1234_5678);
    chk("new_byte", byte_out, 8'h12);
    repeat (4) press();

    // same-cycle load and enter edge: edge dropped
    enter = 1'b1;
    load(32'hCAFE_BEEF);
    enter = 1'b0;
    chk("same_idx", byte_idx, 2'd3);
    repeat (4) press();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      result_valid = ($urandom_range(0, 9) == 0);
      result = $urandom;
      enter = ($urandom_range(0, 2) == 0);
      cyc();
    end
    reset = 1'b0; result_valid = 1'b0; enter = 1'b0;
    repeat (30) cyc();

`ifdef RESULT_AUTOSCROLL_EN
    load(32'h89AB_CDEF);
    repeat (24) cyc();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
